// File: rtl/multi_dice_roller.sv
// Rolls NUM_DICE dice of FACES faces from one push-button: synchroniser, debouncer,
// odometer-style face counters, live LED animation and a latched result with sum.
module multi_dice_roller #(
   parameter int NUM_DICE        = 2,
   parameter int FACES           = 6,
   parameter int DEBOUNCE_CYCLES = 50000,
   localparam int SUM_W          = $clog2(NUM_DICE*FACES+1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      btn,
   output logic [NUM_DICE*FACES-1:0] led,
   output logic [SUM_W-1:0]          sum,
   output logic                      rolling,
   output logic                      valid
);

   localparam int FW = $clog2(FACES);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [FW-1:0] FACE_LAST = FW'(FACES-1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES-1);

   typedef enum logic [1:0] {IDLE, ROLL, LATCH, SHOW} state_t;

   state_t                      state;
   logic                        sync1, sync2;
   logic                        deb, deb_nxt;
   logic [CW-1:0]               cnt;
   logic [FW-1:0]               face [NUM_DICE];
   logic [NUM_DICE-1:0]         adv;
   logic                        carry;
   logic [NUM_DICE*FACES-1:0]   live_led;
   logic [SUM_W-1:0]            total;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // The FSM reacts to the level the debouncer is about to take, so rolling
   // rises in the same edge the debounced level toggles.
   always_comb begin
      deb_nxt = deb;
      if ((sync2 != deb) && (cnt == CNT_LAST))
         deb_nxt = ~deb;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb <= 1'b0;
         cnt <= '0;
      end else if (sync2 == deb) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         deb <= ~deb;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      adv   = '0;
      carry = (state == ROLL);
      for (int unsigned k = 0; k < NUM_DICE; k++) begin
         adv[k] = carry;
         carry  = carry && (face[k] == FACE_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NUM_DICE; k++)
            face[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_DICE; k++)
            if (adv[k])
               face[k] <= (face[k] == FACE_LAST) ? '0 : face[k] + 1'b1;
      end
   end

   always_comb begin
      live_led = '0;
      total    = SUM_W'(NUM_DICE);
      for (int unsigned k = 0; k < NUM_DICE; k++) begin
         live_led[k*FACES + int'(face[k])] = 1'b1;
         total = total + SUM_W'(face[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         led     <= '0;
         sum     <= '0;
         rolling <= 1'b0;
         valid   <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               led <= '0;
               if (deb_nxt) begin
                  state   <= ROLL;
                  rolling <= 1'b1;
               end
            end
            ROLL: begin
               led <= live_led;
               if (!deb_nxt) begin
                  state   <= LATCH;
                  rolling <= 1'b0;
               end
            end
            LATCH: begin
               led   <= live_led;
               sum   <= total;
               valid <= 1'b1;
               state <= SHOW;
            end
            SHOW: begin
               if (deb_nxt) begin
                  state   <= ROLL;
                  rolling <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_dice_roller.sv
// Self-checking bench for multi_dice_roller: directed vectors, corner sequences and
// random presses checked against an arithmetic odometer model.
module tb_multi_dice_roller;

   localparam int ND  = 2;
   localparam int FC  = 6;
   localparam int DB  = 4;
   localparam int LW  = ND*FC;
   localparam int SW  = $clog2(ND*FC+1);

   logic          clk;
   logic          rst_n;
   logic          btn;
   logic [LW-1:0] led;
   logic [SW-1:0] sum;
   logic          rolling;
   logic          valid;

   int checks = 0;
   int errors = 0;
   int vcount = 0;
   int rcount = 0;

   multi_dice_roller #(
      .NUM_DICE(ND),
      .FACES(FC),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn(btn),
      .led(led),
      .sum(sum),
      .rolling(rolling),
      .valid(valid)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (valid === 1'b1) vcount++;
      if (rolling === 1'b1) rcount++;
   end

   typedef struct {
      int            press;
      int            gap;
      int            nvalid;
      int            exp_sum;
      logic [LW-1:0] exp_led;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic press(input int p, input int g);
      btn = 1'b1;
      repeat (p) @(negedge clk);
      btn = 1'b0;
      repeat (g) @(negedge clk);
   endtask

   task automatic do_reset();
      btn   = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Odometer model: after 'total' advances, die k shows digit k of total in base FC.
   function automatic void ref_result(input int total, output int s, output logic [LW-1:0] l);
      int t;
      int d;
      t = total;
      s = 0;
      l = '0;
      for (int k = 0; k < ND; k++) begin
         d = t % FC;
         t = t / FC;
         s = s + d + 1;
         l[k*FC + d] = 1'b1;
      end
   endfunction

   initial begin
      int v0, r0, n, total, exp_s, p, g;
      logic [LW-1:0] exp_l;

      vecs[0] = '{press: 3,  gap: 12, nvalid: 0, exp_sum: 4, exp_led: 12'b000010_000010};
      vecs[1] = '{press: 6,  gap: 12, nvalid: 1, exp_sum: 5, exp_led: 12'b000100_000010};
      vecs[2] = '{press: 29, gap: 14, nvalid: 1, exp_sum: 3, exp_led: 12'b000010_000001};
      vecs[3] = '{press: 4,  gap: 12, nvalid: 1, exp_sum: 7, exp_led: 12'b000010_010000};

      // Reset held with button pressed
      rst_n = 1'b0;
      btn   = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_led", led, 0);
      check("reset_sum", sum, 0);
      check("reset_rolling", rolling, 0);
      check("reset_valid", valid, 0);
      btn = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_reset_idle_led", led, 0);
      check("post_reset_no_roll", rcount, 0);

      // Glitch shorter than the debounce window
      v0 = vcount; r0 = rcount;
      press(3, 12);
      check("glitch_rolling", rcount - r0, 0);
      check("glitch_valid", vcount - v0, 0);
      check("glitch_led", led, 0);

      // Basic roll: rolling latency from raw edge, then 7-cycle press
      v0 = vcount; r0 = rcount;
      btn = 1'b1;
      n = 0;
      while (rolling !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rolling_latency", n, 6);
      repeat (7 - n) @(negedge clk);
      btn = 1'b0;
      repeat (12) @(negedge clk);
      check("basic_valid_pulses", vcount - v0, 1);
      check("basic_roll_cycles", rcount - r0, 7);
      check("basic_sum", sum, 4);
      check("basic_led", led, 12'b000010_000010);

      // Table-driven re-rolls continuing from the previous counters
      for (int i = 0; i < 4; i++) begin
         v0 = vcount; r0 = rcount;
         press(vecs[i].press, vecs[i].gap);
         check($sformatf("vec%0d_valid", i), vcount - v0, vecs[i].nvalid);
         check($sformatf("vec%0d_roll", i), rcount - r0, vecs[i].nvalid != 0 ? vecs[i].press : 0);
         check($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
         check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
      end

      // Carry chain across dice
      do_reset();
      v0 = vcount;
      press(41, 12);
      check("carry_valid", vcount - v0, 1);
      check("carry_sum", sum, 7);
      check("carry_led", led, 12'b000001_100000);

      // Reset asserted mid-roll
      btn = 1'b1;
      n = 0;
      while (rolling !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("midroll_rising", rolling, 1);
      repeat (3) @(negedge clk);
      v0 = vcount;
      rst_n = 1'b0;
      #1;
      check("midroll_led", led, 0);
      check("midroll_sum", sum, 0);
      check("midroll_rolling", rolling, 0);
      check("midroll_valid", valid, 0);
      btn = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("midroll_no_valid", vcount - v0, 0);
      v0 = vcount;
      press(7, 12);
      check("after_reset_valid", vcount - v0, 1);
      check("after_reset_sum", sum, 4);
      check("after_reset_led", led, 12'b000010_000010);

      // Random presses against the odometer model
      do_reset();
      total = 0;
      exp_s = 0;
      exp_l = '0;
      for (int i = 0; i < 20; i++) begin
         p = $urandom_range(30, 1);
         g = $urandom_range(20, 12);
         v0 = vcount; r0 = rcount;
         press(p, g);
         if (p >= DB) begin
            total = total + p;
            ref_result(total, exp_s, exp_l);
         end
         check($sformatf("rnd%0d_p%0d_valid", i, p), vcount - v0, (p >= DB) ? 1 : 0);
         check($sformatf("rnd%0d_p%0d_roll", i, p), rcount - r0, (p >= DB) ? p : 0);
         check($sformatf("rnd%0d_p%0d_sum", i, p), sum, exp_s);
         check($sformatf("rnd%0d_p%0d_led", i, p), led, exp_l);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
